// File: rtl/fetch_pc_unit.sv
// Program-counter / instruction-register stage sequenced by the one-hot
// FT/DC/EX/WB phase strobes from the CPU phase sequencer.
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   ft/dc/ex/wb_clk     one-hot phase strobes (exactly one per active cycle)
//   stall               freezes every register, strobes ignored
//   imem_data           instruction read data for imem_addr
//   br_taken/br_target  branch decision and target, used only in WB
//   imem_addr           instruction fetch address (= pc, combinational)
//   pc, ir, opcode      program counter, instruction register, decoded opcode
//   halted              sticky, set at WB of a HALT_OP instruction
//   phase_err           sticky, set on any out-of-sequence / non-one-hot strobe
//   retire_cnt          number of completed WB phases (wraps)
module fetch_pc_unit #(
    parameter int unsigned     PC_W     = 8,
    parameter int unsigned     INST_W   = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter logic [3:0]      HALT_OP  = 4'hF,
    parameter int unsigned     CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ft_clk,
    input  logic              dc_clk,
    input  logic              ex_clk,
    input  logic              wb_clk,
    input  logic              stall,
    input  logic [INST_W-1:0] imem_data,
    input  logic              br_taken,
    input  logic [PC_W-1:0]   br_target,
    output logic [PC_W-1:0]   imem_addr,
    output logic [PC_W-1:0]   pc,
    output logic [INST_W-1:0] ir,
    output logic [3:0]        opcode,
    output logic              halted,
    output logic              phase_err,
    output logic [CNT_W-1:0]  retire_cnt
);

    localparam int unsigned OP_W = 4;

    typedef enum logic [1:0] {
        PH_FT = 2'd0,
        PH_DC = 2'd1,
        PH_EX = 2'd2,
        PH_WB = 2'd3
    } phase_t;

    phase_t          exp_phase;
    logic            halt_pend;

    logic [3:0]      strobes;
    logic            one_hot;
    phase_t          obs_phase;
    phase_t          obs_next;
    phase_t          exp_next;
    logic            phase_ok;
    logic [OP_W-1:0] ir_op;

    assign imem_addr = pc;
    assign ir_op     = ir[INST_W-1 -: OP_W];

    // Strobe decode and phase-sequence check
    always_comb begin
        strobes   = {wb_clk, ex_clk, dc_clk, ft_clk};
        one_hot   = $onehot(strobes);
        obs_phase = PH_FT;
        case (strobes)
            4'b0001: obs_phase = PH_FT;
            4'b0010: obs_phase = PH_DC;
            4'b0100: obs_phase = PH_EX;
            4'b1000: obs_phase = PH_WB;
            default: obs_phase = PH_FT;
        endcase

        obs_next = PH_FT;
        case (obs_phase)
            PH_FT:   obs_next = PH_DC;
            PH_DC:   obs_next = PH_EX;
            PH_EX:   obs_next = PH_WB;
            default: obs_next = PH_FT;
        endcase

        exp_next = PH_FT;
        case (exp_phase)
            PH_FT:   exp_next = PH_DC;
            PH_DC:   exp_next = PH_EX;
            PH_EX:   exp_next = PH_WB;
            default: exp_next = PH_FT;
        endcase

        phase_ok = one_hot && (obs_phase == exp_phase);
    end

    // Phase tracker and all architectural state
    always_ff @(posedge clk) begin
        if (reset) begin
            pc         <= RESET_PC;
            ir         <= '0;
            opcode     <= '0;
            halted     <= 1'b0;
            phase_err  <= 1'b0;
            retire_cnt <= '0;
            halt_pend  <= 1'b0;
            exp_phase  <= PH_FT;
        end else if (!stall) begin
            if (!phase_ok) begin
                // Resynchronise to the observed phase when it is at least one-hot
                phase_err <= 1'b1;
                if (one_hot) begin
                    exp_phase <= obs_next;
                end
            end else begin
                exp_phase <= exp_next;
                if (!halted) begin
                    case (exp_phase)
                        PH_FT: begin
                            ir <= imem_data;
                        end
                        PH_DC: begin
                            opcode <= ir_op;
                            if (ir_op == HALT_OP) begin
                                halt_pend <= 1'b1;
                            end
                        end
                        PH_WB: begin
                            retire_cnt <= retire_cnt + CNT_W'(1);
                            if (halt_pend) begin
                                halted    <= 1'b1;
                                halt_pend <= 1'b0;
                            end else if (br_taken) begin
                                pc <= br_target;
                            end else begin
                                pc <= pc + PC_W'(1);
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end
        end
    end

endmodule
